// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared fetch constants, FSM encoding and buffer entry type
package fetch_sequencer_pkg;
  typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;
  localparam logic [31:0] DEFAULT_RESET_ADDRESS = 32'h0000_0000;
  localparam int FIFO_DEPTH = 2;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'd3;
  endfunction
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: redirect, instruction-memory and decode handshakes of the fetch stage
interface fetch_sequencer_if;
  logic        redirect_valid;
  logic [31:0] redirect_address;
  logic        mem_req_valid;
  logic [31:0] mem_req_address;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  modport master (
    input  redirect_valid, redirect_address, mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
    output mem_req_valid, mem_req_address, instr_valid, instr, instr_pc
  );
  modport slave (
    output redirect_valid, redirect_address, mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
    input  mem_req_valid, mem_req_address, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_sequencer_buffer.sv
// fetch_buffer: 2-entry {pc, instr} FIFO with push/pop/flush and occupancy count
module fetch_buffer
  import fetch_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);
  fetch_entry_t r_mem [FIFO_DEPTH];
  logic         r_rd;
  logic         r_wr;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;
  always_comb begin
    w_pop  = i_pop && r_count != 2'd0;
    w_push = i_push && (r_count != 2'd2 || w_pop);
  end
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      r_rd    <= r_rd ^ w_pop;
      r_wr    <= r_wr ^ w_push;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end
  // when full, a simultaneous push lands in the slot being popped this cycle
  always_ff @(posedge clk) begin
    if (reset) r_mem <= '{default: '0};
    else if (w_push && !i_flush) r_mem[r_wr] <= i_data;
  end
  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencing, credit-limited instruction fetch and redirect draining
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_ADDRESS = DEFAULT_RESET_ADDRESS
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);
  state_t       r_state;
  state_t       w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [1:0]   r_outstanding;
  logic [1:0]   w_outstanding_next;
  logic [1:0]   r_drop;
  logic [1:0]   w_drop_next;
  logic [1:0]   w_count;
  logic         w_req_valid;
  logic         w_accept;
  logic         w_rsp;
  logic         w_instr_valid;
  logic         w_push;
  logic         w_pop;
  fetch_entry_t w_head;
  fetch_entry_t w_rsp_entry;
  // in FETCH every outstanding request is sequential, so the oldest one sits outstanding words behind the PC
  always_comb begin
    w_req_valid        = !reset && r_state == FETCH && (3'(r_outstanding) + 3'(w_count) < 3'd2);
    w_accept           = w_req_valid && bus.mem_req_ready;
    w_rsp              = bus.mem_rsp_valid;
    w_instr_valid      = !reset && w_count != 2'd0;
    w_push             = r_state == FETCH && w_rsp && !bus.redirect_valid;
    w_pop              = w_instr_valid && bus.instr_ready && !bus.redirect_valid;
    w_rsp_entry        = {r_pc - 32'({r_outstanding, 2'b00}), bus.mem_rsp_data};
    w_outstanding_next = r_outstanding + 2'(w_accept) - 2'(w_rsp);
    w_drop_next        = (r_state == DRAIN) ? r_drop - 2'(w_rsp)
                       : (bus.redirect_valid ? w_outstanding_next : 2'd0);
    w_state_next       = (w_drop_next != 2'd0) ? DRAIN : FETCH;
    w_pc_next          = bus.redirect_valid ? word_align(bus.redirect_address)
                       : (w_accept ? r_pc + 32'd4 : r_pc);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= FETCH;
      r_pc          <= RESET_ADDRESS;
      r_outstanding <= 2'd0;
      r_drop        <= 2'd0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_outstanding <= w_outstanding_next;
      r_drop        <= w_drop_next;
    end
  end
  fetch_buffer u_buffer (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_rsp_entry),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .o_head  (w_head),
    .o_count (w_count)
  );
  assign bus.mem_req_valid   = w_req_valid;
  assign bus.mem_req_address = r_pc;
  assign bus.instr_valid     = w_instr_valid;
  assign bus.instr           = reset ? 32'd0 : w_head.instr;
  assign bus.instr_pc        = reset ? 32'd0 : w_head.pc;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized fetch traffic checked against a queue-based scoreboard
module tb_fetch_sequencer;
  localparam logic [31:0] RST_ADDR = 32'hFFFF_FFF8;
  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } req_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  req_t        inflight[$];
  ent_t        fifo[$];
  logic [31:0] req_pc = RST_ADDR;
  int          n_checks = 0;
  int          n_errors = 0;
  fetch_sequencer_if bus ();
  fetch_sequencer #(.RESET_ADDRESS(RST_ADDR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit rst_in, input int p_ready, input int p_rsp, input int p_iready,
                      input bit redir, input logic [31:0] raddr);
    bit   draining;
    bit   exp_req;
    bit   acc;
    bit   rsp;
    req_t t;
    @(negedge clk);
    reset                = rst_in;
    rsp                  = !rst_in && inflight.size() > 0 && int'($urandom_range(0, 99)) < p_rsp;
    bus.mem_req_ready    = int'($urandom_range(0, 99)) < p_ready;
    bus.mem_rsp_valid    = rsp;
    bus.mem_rsp_data     = rsp ? mem_word(inflight[0].pc) : $urandom;
    bus.redirect_valid   = !rst_in && redir;
    bus.redirect_address = raddr;
    bus.instr_ready      = int'($urandom_range(0, 99)) < p_iready;
    #1;
    draining = 1'b0;
    foreach (inflight[i]) if (inflight[i].stale) draining = 1'b1;
    exp_req = !rst_in && !draining && inflight.size() + fifo.size() < 2;
    check("mem_req_valid", 32'(bus.mem_req_valid), 32'(exp_req));
    if (exp_req) check("mem_req_address", bus.mem_req_address, req_pc);
    check("instr_valid", 32'(bus.instr_valid), 32'(!rst_in && fifo.size() > 0));
    if (rst_in) begin
      check("instr_in_reset", bus.instr, 32'd0);
      check("instr_pc_in_reset", bus.instr_pc, 32'd0);
      inflight.delete();
      fifo.delete();
      req_pc = RST_ADDR;
    end else begin
      if (fifo.size() > 0) begin
        check("instr_pc", bus.instr_pc, fifo[0].pc);
        check("instr", bus.instr, fifo[0].data);
      end
      acc = exp_req && bus.mem_req_ready;
      if (fifo.size() > 0 && bus.instr_ready && !redir) void'(fifo.pop_front());
      if (rsp) begin
        t = inflight.pop_front();
        if (!t.stale && !redir) fifo.push_back('{t.pc, bus.mem_rsp_data});
      end
      if (acc) inflight.push_back('{req_pc, 1'b0});
      if (redir) begin
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        fifo.delete();
        req_pc = raddr & ~32'd3;
      end else if (acc) begin
        req_pc += 32'd4;
      end
    end
  endtask
  initial begin
    bus.redirect_valid   = 1'b0;
    bus.redirect_address = 32'd0;
    bus.mem_req_ready    = 1'b0;
    bus.mem_rsp_valid    = 1'b0;
    bus.mem_rsp_data     = 32'd0;
    bus.instr_ready      = 1'b0;
    repeat (3) step(1'b1, 100, 100, 100, 1'b0, 32'd0);
    repeat (20) step(1'b0, 100, 100, 100, 1'b0, 32'd0);
    repeat (12) step(1'b0, 100, 100, 0, 1'b0, 32'd0);
    repeat (8) step(1'b0, 100, 100, 100, 1'b0, 32'd0);
    repeat (4) step(1'b0, 100, 0, 100, 1'b0, 32'd0);
    step(1'b0, 100, 0, 100, 1'b1, 32'h0000_0103);
    repeat (8) step(1'b0, 100, 100, 100, 1'b0, 32'd0);
    repeat (5) step(1'b0, 100, 100, 100, 1'b0, 32'd0);
    step(1'b0, 100, 100, 100, 1'b1, 32'h2000_0041);
    repeat (8) step(1'b0, 100, 100, 100, 1'b0, 32'd0);
    repeat (4) step(1'b0, 100, 0, 100, 1'b0, 32'd0);
    step(1'b1, 100, 100, 100, 1'b0, 32'd0);
    repeat (10) step(1'b0, 100, 100, 100, 1'b0, 32'd0);
    repeat (4000) step(int'($urandom_range(0, 199)) == 0, 70, 60, 70,
                       int'($urandom_range(0, 15)) == 0, $urandom);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
